fpu_dispatch: RTL
=================

# fpu_dispatch

Request front-end for the floating-point unit `fpu`. Accepts add/sub/mult requests on a valid/ready port and buffers them in a small FIFO. Issues each request to `fpu` with a one-cycle `start` pulse, waits for `done`, then returns the result on a valid/ready response port. Illegal opcodes and hung operations are absorbed here, so the `fpu` core never sees them.

## Interface
- DEPTH, 4: request FIFO entries; power of two, ≥2.
- TIMEOUT, 255: maximum cycles spent waiting for `fpu_done` before aborting; 8-bit counter.
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  FIFO not full.
- req_a  input  32  IEEE-754 single operand A.
- req_b  input  32  operand B.
- req_op  input  2  00 add, 01 sub, 10 mult, 11 illegal.
- rsp_valid  output  1  response held.
- rsp_ready  input  1  consumer accepts response.
- rsp_r  output  32  result word.
- rsp_err  output  1  1 = illegal op or timeout.
- fpu_a, fpu_b  output  32 each  operands to `fpu`.
- fpu_op  output  2  op to `fpu`.
- fpu_start  output  1  start pulse to `fpu`.
- fpu_done  input  1  `fpu` done level.
- fpu_r  input  32  `fpu` result.

## Operation
- **FIFO:** DEPTH×66 bits (a, b, op). Write when `req_valid && req_ready`. Pointers are log2(DEPTH)+1 bits so full and empty can be told apart.
  - `req_ready = !full`.
  - A simultaneous push and pop when full is not allowed: `ready` is already low.
  - A simultaneous push and pop when empty is not possible: the pop requires non-empty.
- **FSM states:** IDLE, ISSUE, GUARD, WAIT, RESP.
- **IDLE:** if the FIFO is non-empty, pop the head into the operand register.
  - op=11 → load the response register with r=0x7FC00000, err=1, go to RESP. `fpu` is not started.
  - Otherwise go to ISSUE.
- **ISSUE:** `fpu_start=1` for exactly this cycle; clear the timeout counter; go to GUARD.
- **GUARD:** one cycle in which `fpu_done` is ignored, because `fpu` clears `done` asynchronously on `start`; go to WAIT.
- **WAIT:** increment the counter each cycle.
  - `fpu_done=1` → capture r=`fpu_r`, err=0, go to RESP.
  - Else, counter == TIMEOUT → r=0x7FC00000, err=1, go to RESP.
  - If `done` and the timeout occur in the same cycle, `done` wins.
- **RESP:** `rsp_valid=1`. On `rsp_ready`, go to IDLE. The FIFO head is not popped in the same cycle.
- **Operand outputs:** `fpu_a/b/op` are driven from the operand register and held stable from ISSUE through the end of RESP.
- **Response outputs:** `rsp_r` and `rsp_err` are stable while `rsp_valid=1`.

## Timing
- **Reset values:** `req_ready=1`, `rsp_valid=0`, `rsp_r=0`, `rsp_err=0`, `fpu_start=0`, `fpu_a=fpu_b=0`, `fpu_op=0`, FIFO empty, FSM in IDLE, counter 0.
- **Reset mid-operation:** drops all queued and in-flight requests; `fpu_start` falls immediately.
- **Latency:**
  - Request accepted at cycle t into an empty, idle block → pop at t+1, `fpu_start` at t+2, earliest `rsp_valid` at t+2+3+N, where N is the number of WAIT cycles before `fpu_done`.
  - Illegal op → `rsp_valid` at t+2.
- **Throughput:** at most one operation in flight; requests keep queueing during WAIT and RESP.
- **Pulse width:** `fpu_start` is never high for two consecutive cycles.

## Configuration
- `FPU_DISPATCH_ZERO_BYPASS_EN` defined: in IDLE, if the popped op ∈ {00, 01, 10} and either operand has exp==0 and frac==0, the result is computed locally (`fpu` has no zero handling) and the FSM goes straight to RESP with err=0.
  - mult → sign = a[31]^b[31], rest zero.
  - add → the non-zero operand; if both are zero, +0 unless both signs are 1.
  - sub → a with b's sign flipped, using the same rules as add.
- Undefined: zero operands are issued to `fpu` like any other request.

## Test plan
- **Single add:** a=0x3F800000, b=0x40000000, op=00; model `fpu_done` 5 cycles after start with `fpu_r`=0x40400000 → `fpu_start` is a single pulse two cycles after the request, then rsp r=0x40400000, err=0.
- **Backpressure and FIFO:** push DEPTH+1 requests back-to-back with `rsp_ready=0` → `req_ready` falls after the ready-gated pushes fill the FIFO, and one request is in flight. With `rsp_ready=1`, responses come out in order.
- **Illegal op:** op=11 → rsp r=0x7FC00000, err=1 at t+2; `fpu_start` never asserts.
- **Timeout:** hold `fpu_done=0` with TIMEOUT=10 → rsp r=0x7FC00000, err=1 after the WAIT counter reaches 10. The next request issues normally.
- **Stale done and reset:** hold `fpu_done=1` high into ISSUE/GUARD → not sampled in GUARD. Asserting `rst` low during WAIT → all outputs return to their reset values the same cycle.
- **Zero bypass (macro on):** mult a=0x80000000, b=0x3F800000 → r=0x80000000, err=0, no `fpu_start`. Macro off → `fpu_start` pulses.

Source files
------------

// File: rtl/fpu_dispatch.sv
// -----------------------------------------------------------------------------
// fpu_dispatch
//
// Request front-end for the floating-point core `fpu`. Add/sub/mult requests
// are accepted on a valid/ready port into a DEPTH-entry FIFO. Each one is
// issued to `fpu` with a single-cycle start pulse. The block then waits for
// `fpu_done_i` and returns the result on a valid/ready response port.
// Illegal opcodes (op=11) and operations that exceed TIMEOUT wait cycles are
// answered locally with a quiet NaN and rsp_err_o=1. `fpu` never sees them.
//
// Parameters
//   DEPTH    request FIFO entries (power of two, >= 2)
//   TIMEOUT  maximum WAIT cycles before aborting (8-bit counter)
//
// Optional feature
//   FPU_DISPATCH_ZERO_BYPASS_EN  when defined, requests that have a zero
//   operand are resolved locally and never reach `fpu`.
//
// Ports
//   clk_i, rst_ni                 clock; asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake (ready = FIFO not full)
//   req_a_i, req_b_i, req_op_i    operands; op 00 add, 01 sub, 10 mult, 11 illegal
//   rsp_valid_o / rsp_ready_i     response handshake
//   rsp_r_o, rsp_err_o            result word; error flag (illegal op or timeout)
//   fpu_a_o, fpu_b_o, fpu_op_o    operands presented to `fpu`
//   fpu_start_o                   one-cycle start pulse to `fpu`
//   fpu_done_i, fpu_r_i           done level and result from `fpu`
// -----------------------------------------------------------------------------
module fpu_dispatch #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    input  logic [1:0]  req_op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_r_o,
    output logic        rsp_err_o,
    output logic [31:0] fpu_a_o,
    output logic [31:0] fpu_b_o,
    output logic [1:0]  fpu_op_o,
    output logic        fpu_start_o,
    input  logic        fpu_done_i,
    input  logic [31:0] fpu_r_i
);

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [7:0]  TMO  = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_RESP
    } state_t;

    // ---------------------------------------------------------------- FIFO
    logic [65:0] mem_q [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        full, empty, push, pop;
    logic [65:0] head;
    logic [31:0] head_a, head_b;
    logic [1:0]  head_op;

    state_t      state_q;
    logic [31:0] opa_q, opb_q;
    logic [1:0]  opop_q;
    logic        start_q;
    logic [7:0]  cnt_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_r_q;
    logic        rsp_err_q;

    // The extra pointer MSB tells a full FIFO from an empty one.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = req_valid_i && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign head_a  = head[65:34];
    assign head_b  = head[33:2];
    assign head_op = head[1:0];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q[AW-1:0]] <= {req_a_i, req_b_i, req_op_i};
    end

`ifdef FPU_DISPATCH_ZERO_BYPASS_EN
    // ------------------------------------------------------- zero bypass
    logic        byp_hit;
    logic [31:0] byp_r;

    // Sum when at least one operand is a signed zero: the other operand wins.
    // Two zeros give -0 only when both are negative.
    function automatic logic [31:0] add_zero(input logic [31:0] x,
                                             input logic [31:0] y);
        if (x[30:0] == '0 && y[30:0] == '0) return {x[31] & y[31], 31'b0};
        else if (x[30:0] == '0)             return y;
        else                                return x;
    endfunction

    always_comb begin
        byp_hit = (head_op != 2'b11) &&
                  (head_a[30:0] == '0 || head_b[30:0] == '0);
        case (head_op)
            2'b00:   byp_r = add_zero(head_a, head_b);
            2'b01:   byp_r = add_zero(head_a, {~head_b[31], head_b[30:0]});
            default: byp_r = {head_a[31] ^ head_b[31], 31'b0};
        endcase
    end
`endif

    // ----------------------------------------------------------------- FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            opa_q       <= '0;
            opb_q       <= '0;
            opop_q      <= '0;
            start_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_r_q     <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        opa_q  <= head_a;
                        opb_q  <= head_b;
                        opop_q <= head_op;
                        if (head_op == 2'b11) begin
                            rsp_r_q     <= QNAN;
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
`ifdef FPU_DISPATCH_ZERO_BYPASS_EN
                        else if (byp_hit) begin
                            rsp_r_q     <= byp_r;
                            rsp_err_q   <= 1'b0;
                            rsp_valid_q <= 1'b1;
                            state_q     <= S_RESP;
                        end
`endif
                        else begin
                            start_q <= 1'b1;
                            state_q <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= S_GUARD;
                end
                // fpu_done_i may still show the previous result here, because
                // `fpu` only clears it in reaction to start.
                S_GUARD: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_q + 8'd1;
                    if (fpu_done_i) begin
                        rsp_r_q     <= fpu_r_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (cnt_q == TMO) begin
                        rsp_r_q     <= QNAN;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready_o = !full;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_r_o     = rsp_r_q;
    assign rsp_err_o   = rsp_err_q;
    assign fpu_a_o     = opa_q;
    assign fpu_b_o     = opb_q;
    assign fpu_op_o    = opop_q;
    assign fpu_start_o = start_q;

endmodule
